// File: rtl/sap_alu_pkg.sv
// sap_alu_pkg: shared types and constants for the SAP arithmetic unit.
// Holds the operation encoding, the control FSM states and the flag bit positions.
package sap_alu_pkg;

    // Operation codes presented on the op port; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5
    } alu_op_e;

    // Control FSM: wait for start, execute, pulse done for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit positions inside the 4-bit flags word {ovf, neg, zero, carry}.
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/sap_alu_mul_seq.sv
// sap_alu_mul_seq: unsigned shift-and-add multiplier, one multiplier bit per step.
// Instantiated by sap_alu_unit only when SAP_ALU_MUL_EN is defined.
// load captures the operands; each step consumes one multiplier bit; done flags
// the final (WIDTH-th) step, and product is the 2*WIDTH value including that step.
module sap_alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Next-state of the multiplier: restart on load, otherwise shift-add on step.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        product  = prod_q + (mplier_q[0] ? mcand_q : '0);
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand};
            mplier_d = mplier;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            prod_d   = product;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    assign done = step && (cnt_q == CW'(WIDTH - 1));

    // Multiplier state registers; cleared so an aborted multiply leaves nothing behind.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sap_alu_unit.sv
// sap_alu_unit: SAP accumulator/B registers, multi-op ALU, registered result and flags.
// Operations run under a start/busy/done handshake; A, B, op and acc_wb are
// snapshotted at the start edge so bus loads during execution cannot disturb them.
// Build option: define SAP_ALU_MUL_EN to implement MUL (op 5) with the sequential
// multiplier; otherwise op 5 behaves like a reserved op.
module sap_alu_unit
    import sap_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             acc_wb,
    input  logic             en_out,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
    logic [2:0]       snap_op_q, snap_op_d;
    logic             snap_wb_q, snap_wb_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             start_fire;
    logic             exec_last;
    logic             alu_upd;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;

    assign start_fire = (state_q == IDLE) && start;

`ifdef SAP_ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_done;

    sap_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .clr_n   (clr_n),
        .load    (start_fire),
        .step    ((state_q == EXEC) && (snap_op_q == OP_MUL)),
        .mcand   (a_q),
        .mplier  (b_q),
        .product (mul_product),
        .done    (mul_done)
    );
`endif

    // ALU on the snapshotted operands; reserved ops keep result and flags as they are.
    always_comb begin
        is_sub    = (snap_op_q == OP_SUB);
        b_eff     = is_sub ? ~snap_b_q : snap_b_q;
        sum       = {1'b0, snap_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        alu_res   = result_q;
        alu_flags = flags_q;
        alu_upd   = 1'b1;
        exec_last = 1'b1;
        case (snap_op_q)
            OP_ADD, OP_SUB: begin
                alu_res          = sum[MSB:0];
                alu_flags        = '0;
                alu_flags[FLG_C] = sum[WIDTH];
                alu_flags[FLG_V] = (snap_a_q[MSB] == b_eff[MSB]) && (sum[MSB] != snap_a_q[MSB]);
            end
            OP_AND: begin
                alu_res   = snap_a_q & snap_b_q;
                alu_flags = '0;
            end
            OP_OR: begin
                alu_res   = snap_a_q | snap_b_q;
                alu_flags = '0;
            end
            OP_XOR: begin
                alu_res   = snap_a_q ^ snap_b_q;
                alu_flags = '0;
            end
`ifdef SAP_ALU_MUL_EN
            OP_MUL: begin
                alu_res          = mul_product[MSB:0];
                alu_flags        = '0;
                alu_flags[FLG_V] = |mul_product[2*WIDTH-1:WIDTH];
                exec_last        = mul_done;
            end
`endif
            default: alu_upd = 1'b0;
        endcase
        if (alu_upd) begin
            alu_flags[FLG_Z] = (alu_res == '0);
            alu_flags[FLG_N] = alu_res[MSB];
        end
    end

    // FSM next state, snapshot capture, result/flag update, write-back and bus loads.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        flags_d   = flags_q;
        snap_a_d  = snap_a_q;
        snap_b_d  = snap_b_q;
        snap_op_d = snap_op_q;
        snap_wb_d = snap_wb_q;
        case (state_q)
            IDLE: begin
                if (start_fire) begin
                    state_d   = EXEC;
                    snap_a_d  = a_q;
                    snap_b_d  = b_q;
                    snap_op_d = op;
                    snap_wb_d = acc_wb;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_d  = DONE;
                    result_d = alu_res;
                    flags_d  = alu_flags;
                    if (snap_wb_q) a_d = alu_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A bus load takes priority over write-back on the same edge.
        if (ld_a) a_d = bus_in;
        if (ld_b) b_d = bus_in;
        busy_d = (state_d == EXEC);
        done_d = (state_d == DONE);
    end

    // All architectural state and registered handshake outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            snap_a_q  <= '0;
            snap_b_q  <= '0;
            snap_op_q <= '0;
            snap_wb_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            snap_a_q  <= snap_a_d;
            snap_b_q  <= snap_b_d;
            snap_op_q <= snap_op_d;
            snap_wb_q <= snap_wb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus_out = en_out ? result_q : '0;
    assign a_out   = a_q;
    assign b_out   = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_sap_alu_unit.sv
// tb_sap_alu_unit: scoreboard bench for sap_alu_unit (WIDTH=8).
// Expected results come from a behavioural model, are queued when an operation
// is launched and compared when done pulses. Honours SAP_ALU_MUL_EN like the RTL.
module tb_sap_alu_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr_n;
    logic [W-1:0] bus_in;
    logic         ld_a, ld_b;
    logic [2:0]   op;
    logic         start, acc_wb, en_out;
    logic [W-1:0] bus_out, a_out, b_out;
    logic         busy, done;
    logic [3:0]   flags;

    sap_alu_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .bus_in  (bus_in),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .op      (op),
        .start   (start),
        .acc_wb  (acc_wb),
        .en_out  (en_out),
        .bus_out (bus_out),
        .a_out   (a_out),
        .b_out   (b_out),
        .busy    (busy),
        .done    (done),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model state mirrored from the operations driven.
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]   m_flags = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        e.res = m_res;
        e.flags = m_flags;
        e.a = a;
        e.b = b;
        e.lat = 1;
        case (o)
            3'd0: begin
                s = int'(a) + int'(b);
                e.res = s[W-1:0];
                e.flags = {(sa + sb > 127) || (sa + sb < -128), e.res[W-1], e.res == 0, s > 255};
            end
            3'd1: begin
                s = int'(a) - int'(b);
                e.res = s[W-1:0];
                e.flags = {(sa - sb > 127) || (sa - sb < -128), e.res[W-1], e.res == 0, a >= b};
            end
            3'd2: begin e.res = a & b; e.flags = {1'b0, e.res[W-1], e.res == 0, 1'b0}; end
            3'd3: begin e.res = a | b; e.flags = {1'b0, e.res[W-1], e.res == 0, 1'b0}; end
            3'd4: begin e.res = a ^ b; e.flags = {1'b0, e.res[W-1], e.res == 0, 1'b0}; end
`ifdef SAP_ALU_MUL_EN
            3'd5: begin
                s = int'(a) * int'(b);
                e.res = s[W-1:0];
                e.flags = {s > 255, e.res[W-1], e.res == 0, 1'b0};
                e.lat = W;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic load_a(input logic [W-1:0] v);
        @(negedge clk);
        bus_in = v; ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0;
        m_a = v;
    endtask

    task automatic load_b(input logic [W-1:0] v);
        @(negedge clk);
        bus_in = v; ld_b = 1'b1;
        @(negedge clk);
        ld_b = 1'b0;
        m_b = v;
    endtask

    // Launch one op. hold keeps start high into EXEC; mld_a/mld_b load mval
    // on the first edge after the start edge.
    task automatic run_op(input logic [2:0] o, input logic wb, input logic hold,
                          input logic mld_a, input logic mld_b, input logic [W-1:0] mval);
        exp_t e, p;
        int lat, busy_cnt, extra;
        @(negedge clk);
        op = o; acc_wb = wb; start = 1'b1;
        e = model(o, m_a, m_b);
        e.b = mld_b ? mval : m_b;
        if (mld_a && e.lat == 1) e.a = mval;
        else if (wb)             e.a = e.res;
        else if (mld_a)          e.a = mval;
        else                     e.a = m_a;
        sb_q.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (mld_a || mld_b) begin
            bus_in = mval; ld_a = mld_a; ld_b = mld_b;
        end
        lat = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
            start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
        end
        p = sb_q.pop_front();
        check("latency", lat, p.lat);
        check("busy_cycles", busy_cnt, p.lat);
        check("result", {24'd0, bus_out}, {24'd0, p.res});
        check("flags", {28'd0, flags}, {28'd0, p.flags});
        check("a_out", {24'd0, a_out}, {24'd0, p.a});
        check("b_out", {24'd0, b_out}, {24'd0, p.b});
        m_res = p.res; m_flags = p.flags; m_a = p.a; m_b = p.b;
        @(negedge clk);
        check("done_pulse_end", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("result_hold", {24'd0, bus_out}, {24'd0, m_res});
        if (hold) begin
            extra = 0;
            repeat (3) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check("start_ignored", extra, 0);
        end
    endtask

    initial begin
        int dcnt;
        clr_n = 1'b0; bus_in = '0; ld_a = 1'b0; ld_b = 1'b0;
        op = '0; start = 1'b0; acc_wb = 1'b0; en_out = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a", {24'd0, a_out}, 32'd0);
        check("rst_b", {24'd0, b_out}, 32'd0);
        check("rst_bus", {24'd0, bus_out}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        clr_n = 1'b1;

        // ADD 25+10, then output enable off/on.
        load_a(8'd25); load_b(8'd10);
        run_op(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("add_35", {24'd0, bus_out}, 32'd35);
        en_out = 1'b0;
        #1 check("en_out_off", {24'd0, bus_out}, 32'd0);
        en_out = 1'b1;
        #1 check("en_out_on", {24'd0, bus_out}, 32'd35);

        // SUB with borrow, SUB to zero.
        load_a(8'd10); load_b(8'd25);
        run_op(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        load_a(8'd25);
        run_op(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("sub_zero_flags", {28'd0, flags}, 32'b0011);

        // Signed overflow on ADD, XOR with write-back.
        load_a(8'd127); load_b(8'd1);
        run_op(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        load_a(8'hF0); load_b(8'h0F);
        run_op(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("xor_wb_a", {24'd0, a_out}, 32'hFF);

        // AND/OR and reserved ops (one with write-back of the unchanged result).
        load_a(8'hC3); load_b(8'h5A);
        run_op(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        run_op(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        run_op(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        run_op(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // MUL (or reserved when the multiplier is not built).
        load_a(8'd25); load_b(8'd10);
        run_op(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        load_a(8'd20); load_b(8'd20);
        run_op(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // start held while busy, B reloaded mid-op, ld_a on the write-back edge.
        load_a(8'd13); load_b(8'd11);
        run_op(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_op(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
        run_op(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_op(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
        check("lda_wins", {24'd0, a_out}, 32'h5A);

        // Asynchronous reset during EXEC with write-back requested.
        load_a(8'd9); load_b(8'd7);
        @(negedge clk);
        op = 3'd5; acc_wb = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr_n = 1'b0;
        #1;
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        check("abort_a", {24'd0, a_out}, 32'd0);
        check("abort_b", {24'd0, b_out}, 32'd0);
        check("abort_bus", {24'd0, bus_out}, 32'd0);
        check("abort_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        m_a = '0; m_b = '0; m_res = '0; m_flags = '0;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_no_wb", {24'd0, a_out}, 32'd0);

        // Operation resumes after reset, then random ALU ops.
        load_a(8'd200); load_b(8'd100);
        run_op(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            load_a(W'($urandom_range(0, 255)));
            load_b(W'($urandom_range(0, 255)));
            run_op(3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sap_alu_unit.md
Name: sap_alu_unit

Overview:
- Parametrised next-generation SAP arithmetic unit: A (accumulator) and B operand registers, a multi-op ALU, a registered result and a flags register, all in one block.
- Replaces the combinational adder/subtractor plus separate A/B registers.
- Operations are launched by a start/busy/done handshake from the controller.
- Result is driven onto the bus through an output enable; optional write-back into A gives true accumulator behaviour.

Parameters:
- WIDTH, 8, data/bus width in bits (>= 4).

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- bus_in  input  WIDTH  data from the common bus.
- ld_a  input  1  load A from bus_in on the next edge.
- ld_b  input  1  load B from bus_in on the next edge.
- op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6-7 reserved.
- start  input  1  launch op (sampled only in IDLE).
- acc_wb  input  1  sampled with start; when 1, the result is also written into A.
- en_out  input  1  drive the result onto bus_out.
- bus_out  output  WIDTH  en_out ? result : 0 (no internal tri-state).
- a_out  output  WIDTH  current A register.
- b_out  output  WIDTH  current B register.
- busy  output  1  high in EXEC.
- done  output  1  one-cycle pulse in DONE.
- flags  output  4  {ovf, neg, zero, carry}.

Behaviour:
- Reset (clr_n low, asynchronous): A, B, result, flags = 0; state = IDLE; busy = done = 0. Applies mid-operation: the operation is aborted and no write-back occurs.
- ld_a/ld_b are honoured in every state; loads and operations are independent.
- At the start edge in IDLE, A, B, op and acc_wb are snapshotted. A load on that same edge does not affect the snapshot, which holds the pre-load values.
- start outside IDLE is ignored (no queueing).
- FSM: IDLE --start--> EXEC. EXEC lasts 1 cycle for ADD/SUB/AND/OR/XOR/reserved and WIDTH cycles for MUL. EXEC --> DONE (1 cycle) --> IDLE.
- result and flags are registered on the edge entering DONE. Latency from the start edge to done high: 1 cycle for ALU ops, WIDTH cycles for MUL.
- ADD: {carry, result} = A + B.
- SUB: A + ~B + 1; carry = 1 means no borrow (A >= B unsigned).
- ovf (ADD/SUB): two's-complement signed overflow.
- AND/OR/XOR: carry = ovf = 0.
- MUL: unsigned shift-and-add, one multiplier bit per cycle. result = low WIDTH bits; ovf = 1 if the high half is nonzero; carry = 0.
- zero = (result == 0); neg = result[WIDTH-1], for all ops.
- Reserved op: result and flags unchanged; done still pulses.
- Write-back: if the snapshotted acc_wb = 1, A <= result on the edge entering DONE. If ld_a is asserted on that same edge, ld_a wins.
- bus_out is combinational from the registered result and en_out; it remains valid between operations.

Optional Feature:
- Macro: SAP_ALU_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined: op 5 is treated as reserved (1-cycle EXEC, result/flags unchanged, done pulses). The multiplier sub-module is not instantiated.

Decomposition:
- Package sap_alu_pkg holds:
  - op encoding enum (OP_ADD..OP_MUL);
  - FSM state enum (IDLE, EXEC, DONE);
  - flag bit index constants (FLG_C=0, FLG_Z=1, FLG_N=2, FLG_V=3).
- One sub-module, sap_alu_mul_seq: WIDTH-parametrised sequential shift-add multiplier with load/step/done, 2*WIDTH product.

Test Plan (WIDTH=8):
- Load A=25, B=10; ADD start -> done 1 cycle later; result=35, flags=0000; en_out=1 gives bus_out=35, en_out=0 gives bus_out=0.
- A=10, B=25, SUB -> result=241, carry=0, neg=1, zero=0, ovf=0. A=25, B=25 SUB -> result=0, zero=1, carry=1.
- A=127, B=1 ADD -> result=128, ovf=1, neg=1. A=0xF0, B=0x0F XOR, acc_wb=1 -> result=0xFF and A=0xFF after done.
- MUL 25*10 -> busy for 8 cycles, result=250, ovf=0. MUL 20*20 -> result=144, ovf=1. Repeat with SAP_ALU_MUL_EN undefined -> done after 1 cycle, result unchanged.
- start while busy is ignored. ld_b=1 with new bus_in during an active MUL does not change the product but updates b_out. ld_a on the write-back edge: A takes bus_in.
- clr_n pulsed low mid-MUL -> immediate IDLE, all outputs 0, no done pulse, no write-back.
